// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: groups the run handshake, operand-store addresses,
// MAC strobes and result-store write port of the matrix-multiply sequencer.
//   start/busy/done      : run handshake
//   a_addr/b_addr        : operand-store read addresses
//   mac_clear/mac_load   : MAC strobes, mac_o is the MAC accumulator
//   c_we/c_addr/c_data   : result-store write port
// master = sequencer side, slave = datapath / top-level side.
interface matmul_sequencer_if #(
  parameter int AW = 4
);
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic          mac_clear;
  logic          mac_load;
  logic [7:0]    mac_o;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [7:0]    c_data;

  modport master (
    input  start, mac_o,
    output busy, done, a_addr, b_addr, mac_clear, mac_load, c_we, c_addr, c_data
  );

  modport slave (
    output start, mac_o,
    input  busy, done, a_addr, b_addr, mac_clear, mac_load, c_we, c_addr, c_data
  );
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks a single MAC through C = A*B for N x N 4-bit
// matrices. Each element takes N ISSUE cycles (one operand pair each), one
// DRAIN cycle to fold in the last registered product, and one WRITE cycle
// that stores the settled accumulator into C.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset (also forces mac_clear)
//   bus  : matmul_sequencer_if.master (handshake, addresses, MAC strobes,
//          result write port)
module matmul_sequencer #(
  parameter int N  = 2,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  matmul_sequencer_if.master bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] i, j, k;
  logic          busy_q, done_q, load_q, clr_q, we_q;
  logic [AW-1:0] a_addr_q, b_addr_q, c_addr_q;

  // Row-major element address r*N+c.
  function automatic logic [AW-1:0] idx(input logic [CW-1:0] r,
                                        input logic [CW-1:0] c);
    return AW'(r) * AW'(N) + AW'(c);
  endfunction

  // Outputs are registered for the cycle being entered, so each branch sets
  // the strobes/addresses that belong to the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      load_q   <= 1'b0;
      clr_q    <= 1'b0;
      we_q     <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      load_q <= 1'b0;
      clr_q  <= 1'b0;
      we_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= ISSUE;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            busy_q   <= 1'b1;
            a_addr_q <= '0;
            b_addr_q <= '0;
            clr_q    <= 1'b1;  // first k=0 cycle clears the accumulator
          end
        end
        ISSUE: begin
          // From k=1 on, the product registered at the previous edge is
          // accumulated; DRAIN picks up the last one.
          load_q <= 1'b1;
          if (k != LAST) begin
            k        <= k + CW'(1);
            a_addr_q <= idx(i, k + CW'(1));
            b_addr_q <= idx(k + CW'(1), j);
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Accumulator settles on this cycle's negedge, stable all of WRITE.
          state    <= WRITE;
          we_q     <= 1'b1;
          c_addr_q <= idx(i, j);
        end
        WRITE: begin
          k <= '0;
          if (j == LAST && i == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state <= ISSUE;
            clr_q <= 1'b1;
            if (j == LAST) begin
              j        <= '0;
              i        <= i + CW'(1);
              a_addr_q <= idx(i + CW'(1), '0);
              b_addr_q <= idx('0, '0);
            end else begin
              j        <= j + CW'(1);
              a_addr_q <= idx(i, '0);
              b_addr_q <= idx('0, j + CW'(1));
            end
          end
        end
        DONE: begin
          // start is ignored here; the earliest next run is the IDLE cycle.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.a_addr    = a_addr_q;
  assign bus.b_addr    = b_addr_q;
  assign bus.mac_load  = load_q;
  // Reset holds the accumulator cleared while it is asserted.
  assign bus.mac_clear = rst | clr_q;
  assign bus.c_we      = we_q;
  assign bus.c_addr    = c_addr_q;
  assign bus.c_data    = we_q ? bus.mac_o : 8'd0;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench: one N=2 and one N=3 sequencer, each driving a behavioural MAC
// (posedge product register, negedge accumulator) and operand memories.
// Expected C comes from a plain triple-loop matrix product mod 256; expected
// per-cycle strobes come from the documented element schedule.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matmul_sequencer_if #(.AW(4)) bus0 ();
  matmul_sequencer_if #(.AW(4)) bus1 ();

  matmul_sequencer #(.N(2), .AW(4)) u_dut2 (.clk(clk), .rst(rst), .bus(bus0));
  matmul_sequencer #(.N(3), .AW(4)) u_dut3 (.clk(clk), .rst(rst), .bus(bus1));

  // Per-instance views, index 0 = N=2, index 1 = N=3.
  logic       start_s [2];
  logic       busy_s  [2], done_s [2], clr_s [2], load_s [2], we_s [2];
  logic [3:0] aa_s    [2], ba_s   [2], ca_s  [2];
  logic [7:0] cd_s    [2];
  logic [3:0] amem [2][16];
  logic [3:0] bmem [2][16];
  logic [7:0] prod [2];
  logic [7:0] acc  [2];

  assign bus0.start = start_s[0];
  assign bus1.start = start_s[1];
  assign bus0.mac_o = acc[0];
  assign bus1.mac_o = acc[1];
  assign busy_s[0] = bus0.busy;      assign busy_s[1] = bus1.busy;
  assign done_s[0] = bus0.done;      assign done_s[1] = bus1.done;
  assign clr_s[0]  = bus0.mac_clear; assign clr_s[1]  = bus1.mac_clear;
  assign load_s[0] = bus0.mac_load;  assign load_s[1] = bus1.mac_load;
  assign we_s[0]   = bus0.c_we;      assign we_s[1]   = bus1.c_we;
  assign aa_s[0]   = bus0.a_addr;    assign aa_s[1]   = bus1.a_addr;
  assign ba_s[0]   = bus0.b_addr;    assign ba_s[1]   = bus1.b_addr;
  assign ca_s[0]   = bus0.c_addr;    assign ca_s[1]   = bus1.c_addr;
  assign cd_s[0]   = bus0.c_data;    assign cd_s[1]   = bus1.c_data;

  // Behavioural MAC fed combinationally from the operand memories.
  always @(posedge clk)
    for (int u = 0; u < 2; u++)
      prod[u] <= 8'(amem[u][aa_s[u]]) * 8'(bmem[u][ba_s[u]]);

  always @(negedge clk)
    for (int u = 0; u < 2; u++)
      if (clr_s[u])       acc[u] <= 8'd0;
      else if (load_s[u]) acc[u] <= acc[u] + prod[u];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_rand(input int u);
    for (int e = 0; e < 16; e++) begin
      amem[u][e] = 4'($urandom_range(0, 15));
      bmem[u][e] = 4'($urandom_range(0, 15));
    end
  endtask

  // Call at #1 after an edge in IDLE; the run starts at the next edge.
  // Returns at #1 into the DONE cycle.
  task automatic run(input int u, input int n, input bit hold);
    int expc[16];
    int t, e, ph;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        int s = 0;
        for (int kk = 0; kk < n; kk++) s += amem[u][r*n+kk] * bmem[u][kk*n+c];
        expc[r*n+c] = s % 256;
      end
    t = n * n * (n + 2);
    start_s[u] = 1'b1;
    for (int c = 1; c <= t + 1; c++) begin
      @(posedge clk); #1;
      if (c == 1 && !hold) start_s[u] = 1'b0;
      if (c <= t) begin
        e  = (c - 1) / (n + 2);
        ph = (c - 1) % (n + 2);
        chk($sformatf("u%0d c%0d busy", u, c), busy_s[u], 1);
        chk($sformatf("u%0d c%0d done", u, c), done_s[u], 0);
        chk($sformatf("u%0d c%0d clear", u, c), clr_s[u], int'(ph == 0));
        chk($sformatf("u%0d c%0d load", u, c), load_s[u], int'(ph >= 1 && ph <= n));
        chk($sformatf("u%0d c%0d c_we", u, c), we_s[u], int'(ph == n + 1));
        if (ph < n) begin
          chk($sformatf("u%0d c%0d a_addr", u, c), aa_s[u], (e / n) * n + ph);
          chk($sformatf("u%0d c%0d b_addr", u, c), ba_s[u], ph * n + e % n);
        end
        if (ph == n + 1) begin
          chk($sformatf("u%0d e%0d c_addr", u, e), ca_s[u], e);
          chk($sformatf("u%0d e%0d c_data", u, e), cd_s[u], expc[e]);
        end
      end else begin
        chk($sformatf("u%0d done pulse", u), done_s[u], 1);
        chk($sformatf("u%0d busy at done", u), busy_s[u], 0);
        chk($sformatf("u%0d c_we at done", u), we_s[u], 0);
      end
    end
  endtask

  task automatic idle_cycle(input int u);
    @(posedge clk); #1;
    chk($sformatf("u%0d idle busy", u), busy_s[u], 0);
    chk($sformatf("u%0d idle done", u), done_s[u], 0);
    chk($sformatf("u%0d idle c_data", u), cd_s[u], 0);
  endtask

  initial begin
    rst = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    for (int e = 0; e < 16; e++) begin
      amem[0][e] = '0; bmem[0][e] = '0; amem[1][e] = '0; bmem[1][e] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst u%0d busy", u), busy_s[u], 0);
      chk($sformatf("rst u%0d done", u), done_s[u], 0);
      chk($sformatf("rst u%0d c_we", u), we_s[u], 0);
      chk($sformatf("rst u%0d load", u), load_s[u], 0);
      chk($sformatf("rst u%0d clear", u), clr_s[u], 1);
      chk($sformatf("rst u%0d a_addr", u), aa_s[u], 0);
      chk($sformatf("rst u%0d b_addr", u), ba_s[u], 0);
      chk($sformatf("rst u%0d c_addr", u), ca_s[u], 0);
      chk($sformatf("rst u%0d c_data", u), cd_s[u], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic product: C = 19, 22, 43, 50.
    amem[0][0] = 1; amem[0][1] = 2; amem[0][2] = 3; amem[0][3] = 4;
    bmem[0][0] = 5; bmem[0][1] = 6; bmem[0][2] = 7; bmem[0][3] = 8;
    run(0, 2, 1'b0);
    idle_cycle(0);

    // Wrap-around: every element 450 mod 256.
    for (int e = 0; e < 4; e++) begin amem[0][e] = 15; bmem[0][e] = 15; end
    run(0, 2, 1'b0);
    idle_cycle(0);

    // No carry-over between elements.
    amem[0][0] = 1; amem[0][1] = 0; amem[0][2] = 0; amem[0][3] = 1;
    bmem[0][0] = 9; bmem[0][1] = 0; bmem[0][2] = 0; bmem[0][3] = 15;
    run(0, 2, 1'b0);
    idle_cycle(0);

    // start held high: second run only from the IDLE cycle after DONE.
    fill_rand(0);
    run(0, 2, 1'b1);
    idle_cycle(0);
    run(0, 2, 1'b1);
    start_s[0] = 1'b0;
    idle_cycle(0);

    // Reset during the second element's ISSUE (cycle 6).
    fill_rand(0);
    start_s[0] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) start_s[0] = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("rst mid clear", clr_s[0], 1);
    @(posedge clk); #1;
    chk("rst mid busy", busy_s[0], 0);
    chk("rst mid c_we", we_s[0], 0);
    chk("rst mid load", load_s[0], 0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post rst c%0d c_we", c), we_s[0], 0);
      chk($sformatf("post rst c%0d done", c), done_s[0], 0);
      chk($sformatf("post rst c%0d busy", c), busy_s[0], 0);
    end
    run(0, 2, 1'b0);
    idle_cycle(0);

    // N=3 strobe alignment and product against the reference.
    for (int r = 0; r < 3; r++) begin
      fill_rand(1);
      run(1, 3, 1'b0);
      idle_cycle(1);
    end

    // Random N=2 runs.
    for (int r = 0; r < 3; r++) begin
      fill_rand(0);
      run(0, 2, 1'b0);
      idle_cycle(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
